alu_core: RTL and testbench
===========================

# alu_core

Sequenced ALU datapath that consumes the 4-bit `alu_control` code from the ALU control decoder and the two register operands, and produces a registered result plus NZCV status flags. Single-cycle operations finish one cycle after issue; MULS uses an iterative shift-add multiplier. A start/busy/done handshake lets the pipeline stall while a multiply is in flight.

## Interface
- `WIDTH`, 32: operand/result width in bits (≥ 4).
- `clk`  in  1: clock, all state updates on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: issue request; sampled only when `busy`=0.
- `alu_control`  in  4: operation code from the ALU control decoder.
- `op_a`  in  WIDTH: first operand (captured at issue).
- `op_b`  in  WIDTH: second operand (captured at issue).
- `result`  out  WIDTH: registered result, held until next completion.
- `flags`  out  4: registered {N,Z,C,V}.
- `busy`  out  1: operation in flight; `start` ignored.
- `done`  out  1: one-cycle pulse; `result`/`flags` valid and updated this cycle.

## Operation
- Codes: 0 ADCS a+b+C; 1 ADD a+b; 2 SBCS a+~b+C; 3 SUBS a-b; 4 RSBS b-a; 5 MULS low WIDTH bits of a*b; 6 ANDS a&b; 7 ORRS a|b; 8 CMP a-b; 9–15 undefined.
- C used by ADCS/SBCS is the registered flag value at issue.
- Arithmetic in WIDTH+1 bits; C = bit WIDTH of the sum (subtract: C=1 means no borrow). V = signed overflow of the two's-complement add/sub.
- Flag update: ADCS, SBCS, SUBS, RSBS, CMP update NZCV. ANDS, ORRS, MULS update N, Z only; C, V held. ADD updates no flags.
- CMP: flags from a-b; `result` also loads a-b.
- Undefined codes: `result` loads 0, flags held, completes as single-cycle op.
- N = result[WIDTH-1]; Z = (result == 0).
- FSM states: IDLE, MUL. IDLE + start + code≠5 → stay IDLE, commit next edge. IDLE + start + code 5 → MUL, load multiplicand/multiplier/accumulator, counter=0. MUL: each cycle add multiplicand to accumulator if multiplier LSB=1, shift multiplicand left, multiplier right, counter+1; after WIDTH iterations commit and return to IDLE.
- Operands captured at issue; changes on `op_a`/`op_b`/`alu_control` while busy have no effect.

## Timing
- Reset: `result`=0, `flags`=4'b0000, `busy`=0, `done`=0, FSM=IDLE, counter=0.
- Single-cycle op: `start` at edge k → `result`, `flags`, `done`=1 visible after edge k+1; `busy` stays 0; back-to-back issue every cycle allowed.
- MULS: `busy`=1 from edge k+1 through completion; `done`=1 and `busy`=0 after edge k+WIDTH+1 (latency WIDTH+1). Next `start` accepted in the cycle `done` is high.
- `start` while `busy`=1: ignored, not queued.
- `rst` asserted mid-multiply: abort at that edge, all outputs to reset values, no `done`.
- `rst` and `start` same cycle: reset wins, request dropped.

## Configuration
- `ALU_FAST_MUL_EN` defined: MULS computed combinationally, completes as single-cycle op (latency 1, `busy` never asserted); MUL state and counter not built.
- Not defined: iterative multiplier as above, latency WIDTH+1.

## Test plan
- Reset: assert `rst` 2 cycles → `result`=0, `flags`=0000, `busy`=0, `done`=0.
- ADCS carry chain: SUBS 5-3 (sets C=1), then ADCS 0xFFFFFFFF+0x00000000 → `result`=0, flags N0 Z1 C1 V0.
- Overflow: SUBS 0x80000000-1 → `result`=0x7FFFFFFF, flags N0 Z0 C1 V1; then ADD 1+1 → `result`=2, flags unchanged.
- MULS iterative: 0x0001_0003 * 0x0000_0005 → `busy`=1 for 32 cycles, `done` after edge k+33, `result`=0x0005_000F, C/V held; `start` pulsed mid-multiply ignored.
- CMP/RSBS: CMP 3 vs 7 → `result`=0xFFFFFFFC, N1 Z0 C0 V0; RSBS a=3 b=7 → `result`=4, C1.
- Reset mid-multiply at cycle 10 → no `done`, outputs to reset values, next ANDS 0xF0 & 0x3C → `result`=0x30 after one cycle.

Source files
------------

// File: rtl/alu_core.sv
// alu_core: sequenced ALU datapath with a registered result and NZCV flags.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        issue request, sampled only while busy is low
//   alu_control  4-bit operation code
//   op_a, op_b   operands, captured at issue
//   result       registered result, held until the next completion
//   flags        registered {N,Z,C,V}
//   busy         multiply in flight; start is ignored
//   done         one-cycle completion pulse
//
// Operation codes
//   0 ADCS, 1 ADD, 2 SBCS, 3 SUBS, 4 RSBS, 5 MULS, 6 ANDS, 7 ORRS, 8 CMP.
//   Codes 9-15 load a zero result, hold the flags and complete in one cycle.
//
// Build option
//   ALU_FAST_MUL_EN  When defined, MULS is a single-cycle combinational
//                    multiply and busy is never raised. When undefined, MULS
//                    uses an iterative shift-add unit with latency WIDTH+1.

module alu_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_ADCS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SBCS = 4'd2;
  localparam logic [3:0] OP_SUBS = 4'd3;
  localparam logic [3:0] OP_RSBS = 4'd4;
  localparam logic [3:0] OP_MULS = 4'd5;
  localparam logic [3:0] OP_ANDS = 4'd6;
  localparam logic [3:0] OP_ORRS = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;

  // {N,Z} for a given result value.
  function automatic logic [1:0] nz_of(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v == '0};
  endfunction

  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             done_q;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;

`ifdef ALU_FAST_MUL_EN
  logic [WIDTH-1:0] prod;
  assign prod = op_a * op_b;
`endif

  // Every add/subtract goes through one WIDTH+1 adder: subtraction adds the
  // inverted subtrahend with carry-in, so C=1 means no borrow and V compares
  // the signs of the actual adder inputs.
  always_comb begin
    add_x   = op_a;
    add_y   = op_b;
    add_cin = 1'b0;
    case (alu_control)
      OP_ADCS: add_cin = flags_q[1];
      OP_SBCS: begin
        add_y   = ~op_b;
        add_cin = flags_q[1];
      end
      OP_SUBS, OP_CMP: begin
        add_y   = ~op_b;
        add_cin = 1'b1;
      end
      OP_RSBS: begin
        add_x   = op_b;
        add_y   = ~op_a;
        add_cin = 1'b1;
      end
      default: ;
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

    res_d   = '0;
    flags_d = flags_q;
    case (alu_control)
      OP_ADCS, OP_SBCS, OP_SUBS, OP_RSBS, OP_CMP: begin
        res_d   = sum[WIDTH-1:0];
        flags_d = {nz_of(sum[WIDTH-1:0]), sum[WIDTH], ovf};
      end
      OP_ADD: res_d = sum[WIDTH-1:0];
      OP_ANDS: begin
        res_d   = op_a & op_b;
        flags_d = {nz_of(op_a & op_b), flags_q[1:0]};
      end
      OP_ORRS: begin
        res_d   = op_a | op_b;
        flags_d = {nz_of(op_a | op_b), flags_q[1:0]};
      end
`ifdef ALU_FAST_MUL_EN
      OP_MULS: begin
        res_d   = prod;
        flags_d = {nz_of(prod), flags_q[1:0]};
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_FAST_MUL_EN

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        result_q <= res_d;
        flags_q  <= flags_d;
        done_q   <= 1'b1;
      end
    end
  end

  assign busy = 1'b0;

`else

  typedef enum logic {IDLE, MUL} state_e;

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;

  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (alu_control == OP_MULS) begin
              state_q  <= MUL;
              mcand_q  <= op_a;
              mplier_q <= op_b;
              acc_q    <= '0;
              cnt_q    <= '0;
            end else begin
              result_q <= res_d;
              flags_q  <= flags_d;
              done_q   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Last iteration commits the freshly accumulated value directly.
          if (cnt_q == CNT_LAST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= acc_d;
            flags_q  <= {nz_of(acc_d), flags_q[1:0]};
            done_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == MUL);

`endif

  assign result = result_q;
  assign flags  = flags_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_core.sv
// Testbench for alu_core: directed scenarios with literal expectations plus
// randomized traffic, all compared against a behavioural model.
module tb_alu_core;

  localparam int unsigned W = 32;
  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W - 1));
  localparam longint unsigned MASK = (longint'(1) <<< W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   alu_control;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  alu_core #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .result      (result),
    .flags       (flags),
    .busy        (busy),
    .done        (done)
  );

  int unsigned vecs = 0;
  int unsigned errs = 0;
  logic        chk_en = 1'b0;

  // Behavioural model state.
  logic [W-1:0] m_res;
  logic [3:0]   m_flags;
  logic         m_busy;
  logic         m_done;
  int           m_left;
  logic [W-1:0] m_prod;

  // Literal-expectation requests from the stimulus process.
  int unsigned  lit_req = 0;
  int unsigned  lit_ack = 0;
  string        lit_name;
  logic [W-1:0] lit_res;
  logic [3:0]   lit_flags;
  logic         lit_busy;
  logic         lit_done;
  logic         lit_use_cnt = 1'b0;
  int           lit_cnt_act;
  int           lit_cnt_exp;

  always @(posedge clk) begin : model
    logic [W-1:0]    r;
    logic [3:0]      f;
    logic            bz;
    logic            dn;
    int              left;
    logic [W-1:0]    prod;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned s;
    longint          sa;
    longint          sb;
    longint          sv;
    logic            arith;
    logic            nz_only;
    r = m_res; f = m_flags; bz = m_busy; left = m_left; prod = m_prod;
    dn = 1'b0; arith = 1'b0; nz_only = 1'b0; s = 0; sv = 0;
    if (rst) begin
      r = '0; f = '0; bz = 1'b0; left = 0;
    end else if (bz) begin
      left = left - 1;
      if (left == 0) begin
        bz = 1'b0; dn = 1'b1; r = prod; nz_only = 1'b1;
      end
    end else if (start) begin
      ua = longint'(op_a); ub = longint'(op_b);
      sa = longint'($signed(op_a)); sb = longint'($signed(op_b));
      dn = 1'b1;
      case (alu_control)
        4'd0: begin s = ua + ub + longint'(f[1]); sv = sa + sb + longint'(f[1]); arith = 1'b1; end
        4'd1: r = W'(ua + ub);
        4'd2: begin s = ua + (MASK - ub) + longint'(f[1]); sv = sa - sb - 1 + longint'(f[1]); arith = 1'b1; end
        4'd3, 4'd8: begin s = ua + (MASK - ub) + 1; sv = sa - sb; arith = 1'b1; end
        4'd4: begin s = ub + (MASK - ua) + 1; sv = sb - sa; arith = 1'b1; end
        4'd5: begin
          prod = W'(ua * ub);
`ifdef ALU_FAST_MUL_EN
          r = prod; nz_only = 1'b1;
`else
          bz = 1'b1; left = W; dn = 1'b0;
`endif
        end
        4'd6: begin r = op_a & op_b; nz_only = 1'b1; end
        4'd7: begin r = op_a | op_b; nz_only = 1'b1; end
        default: r = '0;
      endcase
      if (arith) begin
        r = s[W-1:0];
        f = {s[W-1], s[W-1:0] == '0, s[W], (sv > SMAX) || (sv < SMIN)};
      end
    end
    if (nz_only) begin
      f[3] = r[W-1];
      f[2] = (r == '0);
    end
    m_res <= r; m_flags <= f; m_busy <= bz; m_done <= dn; m_left <= left; m_prod <= prod;
  end

  always @(negedge clk) begin : compare
    int unsigned nv;
    int unsigned ne;
    nv = 0; ne = 0;
    if (chk_en) begin
      nv = nv + 1;
      if (result !== m_res)   begin ne++; $display("FAIL model_result got %h want %h t=%0t", result, m_res, $time); end
      if (flags !== m_flags)  begin ne++; $display("FAIL model_flags got %b want %b t=%0t", flags, m_flags, $time); end
      if (busy !== m_busy)    begin ne++; $display("FAIL model_busy got %b want %b t=%0t", busy, m_busy, $time); end
      if (done !== m_done)    begin ne++; $display("FAIL model_done got %b want %b t=%0t", done, m_done, $time); end
    end
    if (lit_req != lit_ack) begin
      nv = nv + 1;
      if (result !== lit_res)  begin ne++; $display("FAIL %s result got %h want %h", lit_name, result, lit_res); end
      if (flags !== lit_flags) begin ne++; $display("FAIL %s flags got %b want %b", lit_name, flags, lit_flags); end
      if (busy !== lit_busy)   begin ne++; $display("FAIL %s busy got %b want %b", lit_name, busy, lit_busy); end
      if (done !== lit_done)   begin ne++; $display("FAIL %s done got %b want %b", lit_name, done, lit_done); end
      if (lit_use_cnt && (lit_cnt_act != lit_cnt_exp)) begin
        ne++; $display("FAIL %s busy_cycles got %0d want %0d", lit_name, lit_cnt_act, lit_cnt_exp);
      end
      lit_ack <= lit_req;
    end
    vecs <= vecs + nv;
    errs <= errs + ne;
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; alu_control = op; op_a = a; op_b = b;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic expect_lit(input string name, input logic [W-1:0] r, input logic [3:0] f,
                            input logic bz, input logic dn);
    lit_name = name; lit_res = r; lit_flags = f; lit_busy = bz; lit_done = dn;
    lit_req = lit_req + 1;
    @(negedge clk); #1;
    lit_use_cnt = 1'b0;
  endtask

  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 3 * W && !done; i++) begin
      if (busy) nb++;
      @(posedge clk); #2;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  int nb;

  initial begin
    rst = 1'b1; start = 1'b0; alu_control = '0; op_a = '0; op_b = '0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(posedge clk); #2;
    expect_lit("reset", '0, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

    issue(4'd3, 32'd5, 32'd3);
    expect_lit("subs_5_3", 32'd2, 4'b0010, 1'b0, 1'b1);
    issue(4'd0, 32'hFFFF_FFFF, 32'h0);
    expect_lit("adcs_carry", 32'h0, 4'b0110, 1'b0, 1'b1);

    issue(4'd3, 32'h8000_0000, 32'd1);
    expect_lit("subs_ovf", 32'h7FFF_FFFF, 4'b0011, 1'b0, 1'b1);
    issue(4'd1, 32'd1, 32'd1);
    expect_lit("add_noflags", 32'd2, 4'b0011, 1'b0, 1'b1);

    issue(4'd5, 32'h0001_0003, 32'h0000_0005);
    repeat (4) begin @(posedge clk); #2; end
    issue(4'd1, 32'd7, 32'd7);
    alu_control = 4'd6; op_a = '1; op_b = '1;
    wait_done(nb);
    nb = nb + 5;
    lit_use_cnt = 1'b1; lit_cnt_act = nb;
`ifdef ALU_FAST_MUL_EN
    lit_cnt_exp = 5;
`else
    lit_cnt_exp = W;
`endif
    expect_lit("muls", 32'h0005_000F, 4'b0011, 1'b0, 1'b1);

    issue(4'd8, 32'd3, 32'd7);
    expect_lit("cmp_3_7", 32'hFFFF_FFFC, 4'b1000, 1'b0, 1'b1);
    issue(4'd9, 32'd3, 32'd7);
    expect_lit("undef_9", 32'h0, 4'b1000, 1'b0, 1'b1);
    issue(4'd4, 32'd3, 32'd7);
    expect_lit("rsbs", 32'd4, 4'b0010, 1'b0, 1'b1);

    issue(4'd5, 32'd123, 32'd456);
    repeat (9) begin @(posedge clk); #2; end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    expect_lit("rst_mid_mul", '0, 4'b0000, 1'b0, 1'b0);
    issue(4'd6, 32'hF0, 32'h3C);
    expect_lit("ands_after_rst", 32'h30, 4'b0000, 1'b0, 1'b1);

    rst = 1'b1; start = 1'b1; alu_control = 4'd1; op_a = 32'd1; op_b = 32'd1;
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0;
    expect_lit("rst_and_start", '0, 4'b0000, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      start       = ($urandom_range(0, 9) < 7);
      alu_control = 4'($urandom_range(0, 15));
      op_a        = pick();
      op_b        = pick();
      @(posedge clk); #2;
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
